pe_addr_gen: RTL and testbench

Parametrised local address generator inside each PE. It replaces the fixed two-stream kernel/neuron controller with NCH independent row/column address channels. Each channel has its own pitch, strides, offsets and optional automatic row wrap. Commands arrive over a valid/ready handshake and are serialised through a single registered multiply stage that produces per-channel store addresses.

---
 rtl/pe_addr_gen.sv | 255 +++++++++++++++++++++++++
 tb/tb_pe_addr_gen.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/pe_addr_gen.sv
// -----------------------------------------------------------------------------
// pe_addr_gen -- per-PE local address generator.
//
// NCH independent row/column address channels. A command is taken over a
// valid/ready handshake. The channel counters update on the accept edge. On the
// next edge a single multiply stage produces the store address of the addressed
// channel, or of every channel for INIT_ALL. This gives a throughput of one
// command every two cycles.
//
// Optional build macro: AUTO_WRAP_EN
//   When it is defined, INCR/INCR1 wrap the column to 0 and advance the row
//   once the column reaches cfg_cols[ch]. A cfg_cols value of 0 disables the
//   wrap. When it is undefined, cfg_cols is ignored and wrapped stays 0.
//
// Ports:
//   CLK, RSTn          clock (rising edge), async active-low reset
//   cmd_valid/ready    command handshake; ready is low during the CALC cycle
//   cmd_op[2:0]        INIT, HOLD, INCR, JUMP, INCR1, SET_ROW_OFST,
//                      SET_COL_OFST, INIT_ALL
//   cmd_ch[CW-1:0]     target channel; values >= NCH are consumed with no effect
//   pe_sel, set_data   offset write enable and value for the SET ops
//   cfg_step           per-channel row pitch            (ch i at [i*A +: A])
//   cfg_col_stride     per-channel column stride        (ch i at [i*SW +: SW])
//   cfg_row_stride     per-channel row stride           (ch i at [i*SW +: SW])
//   cfg_cols           per-channel columns per row      (ch i at [i*A +: A])
//   addr               registered address per channel   (ch i at [i*A +: A])
//   addr_valid         one-cycle pulse per updated channel
//   wrapped            one-cycle pulse when an automatic row wrap occurred
// -----------------------------------------------------------------------------
module pe_addr_gen #(
    parameter int NCH = 2,
    parameter int A   = 7,
    parameter int OW  = 2,
    parameter int SW  = 4,
    localparam int CW = (NCH > 1) ? $clog2(NCH) : 1
) (
    input  logic              CLK,
    input  logic              RSTn,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [2:0]        cmd_op,
    input  logic [CW-1:0]     cmd_ch,
    input  logic              pe_sel,
    input  logic [OW-1:0]     set_data,
    input  logic [NCH*A-1:0]  cfg_step,
    input  logic [NCH*SW-1:0] cfg_col_stride,
    input  logic [NCH*SW-1:0] cfg_row_stride,
    input  logic [NCH*A-1:0]  cfg_cols,
    output logic [NCH*A-1:0]  addr,
    output logic [NCH-1:0]    addr_valid,
    output logic [NCH-1:0]    wrapped
);

    localparam logic [2:0] OP_INIT     = 3'b000;
    localparam logic [2:0] OP_HOLD     = 3'b001;
    localparam logic [2:0] OP_INCR     = 3'b010;
    localparam logic [2:0] OP_JUMP     = 3'b011;
    localparam logic [2:0] OP_INCR1    = 3'b100;
    localparam logic [2:0] OP_SET_ROW  = 3'b101;
    localparam logic [2:0] OP_SET_COL  = 3'b110;
    localparam logic [2:0] OP_INIT_ALL = 3'b111;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_CALC = 1'b1
    } state_t;

    state_t          r_state;
    state_t          w_state_nx;
    logic            r_cmd_ready;
    logic [2:0]      r_op;
    logic [CW-1:0]   r_ch;
    logic            r_ch_ok;
    logic            w_accept;
    logic            w_ch_ok;

    assign w_accept  = cmd_valid && r_cmd_ready;
    assign w_ch_ok   = (32'(cmd_ch) < 32'(NCH));
    assign cmd_ready = r_cmd_ready;

`ifndef AUTO_WRAP_EN
    // Column limits only matter for the auto-wrap build.
    logic w_unused_cols;
    assign w_unused_cols = ^cfg_cols;
`endif

    // Next-state logic: IDLE accepts a command, CALC always lasts one cycle.
    always_comb begin
        w_state_nx = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_accept) begin
                    w_state_nx = ST_CALC;
                end else begin
                    w_state_nx = ST_IDLE;
                end
            end
            ST_CALC: w_state_nx = ST_IDLE;
            default: w_state_nx = ST_IDLE;
        endcase
    end

    // State register, registered ready, and the command latched for CALC.
    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            r_state     <= ST_IDLE;
            r_cmd_ready <= 1'b1;
            r_op        <= 3'b000;
            r_ch        <= {CW{1'b0}};
            r_ch_ok     <= 1'b0;
        end else begin
            r_state     <= w_state_nx;
            r_cmd_ready <= (w_state_nx == ST_IDLE);
            if (w_accept) begin
                r_op    <= cmd_op;
                r_ch    <= cmd_ch;
                r_ch_ok <= w_ch_ok;
            end
        end
    end

    for (genvar i = 0; i < NCH; i++) begin : g_ch
        logic [A-1:0]  w_step;
        logic [SW-1:0] w_cstride;
        logic [SW-1:0] w_rstride;
        logic [A-1:0]  w_inc;
        logic [A-1:0]  w_row_nx;
        logic [A-1:0]  w_col_nx;
        logic [OW-1:0] w_rofs_nx;
        logic [OW-1:0] w_cofs_nx;
        logic          w_wrap_nx;
        logic          w_hit;
        logic          w_all;
        logic          w_upd;
        logic [A-1:0]  w_rsum;
        logic [A-1:0]  w_addr_calc;
        logic [A-1:0]  r_row;
        logic [A-1:0]  r_col;
        logic [A-1:0]  r_addr;
        logic [OW-1:0] r_rofs;
        logic [OW-1:0] r_cofs;
        logic          r_wrap_pend;
        logic          r_valid;
        logic          r_wrapped;

        assign w_step    = cfg_step[i*A +: A];
        assign w_cstride = cfg_col_stride[i*SW +: SW];
        assign w_rstride = cfg_row_stride[i*SW +: SW];
        assign w_inc     = (cmd_op == OP_INCR1) ? A'(1'b1) : A'(w_cstride);
        assign w_hit     = w_accept && w_ch_ok && (cmd_ch == CW'(i));
        assign w_all     = w_accept && w_ch_ok && (cmd_op == OP_INIT_ALL);
        assign w_upd     = (r_state == ST_CALC) && r_ch_ok &&
                           ((r_op == OP_INIT_ALL) || (r_ch == CW'(i)));

`ifdef AUTO_WRAP_EN
        logic [A-1:0] w_cols;
        logic [A:0]   w_nc;
        assign w_cols = cfg_cols[i*A +: A];
        // The extra bit keeps the wrap compare exact when col+inc overflows A bits.
        assign w_nc   = {1'b0, r_col} + {1'b0, w_inc};
`endif

        // Counter/offset update for this channel on an accepted command.
        always_comb begin
            w_row_nx  = r_row;
            w_col_nx  = r_col;
            w_rofs_nx = r_rofs;
            w_cofs_nx = r_cofs;
            w_wrap_nx = 1'b0;
            if (w_all) begin
                w_row_nx = {A{1'b0}};
                w_col_nx = {A{1'b0}};
            end else if (w_hit) begin
                case (cmd_op)
                    OP_INIT: begin
                        w_row_nx = {A{1'b0}};
                        w_col_nx = {A{1'b0}};
                    end
                    OP_INCR, OP_INCR1: begin
`ifdef AUTO_WRAP_EN
                        if ((w_cols != {A{1'b0}}) && (w_nc >= {1'b0, w_cols})) begin
                            w_col_nx  = {A{1'b0}};
                            w_row_nx  = r_row + A'(w_rstride);
                            w_wrap_nx = 1'b1;
                        end else begin
                            w_col_nx  = w_nc[A-1:0];
                        end
`else
                        w_col_nx = r_col + w_inc;
`endif
                    end
                    OP_JUMP: begin
                        w_row_nx = r_row + A'(w_rstride);
                        w_col_nx = {A{1'b0}};
                    end
                    OP_SET_ROW: begin
                        if (pe_sel) begin
                            w_rofs_nx = set_data;
                        end else begin
                            w_rofs_nx = r_rofs;
                        end
                    end
                    OP_SET_COL: begin
                        if (pe_sel) begin
                            w_cofs_nx = set_data;
                        end else begin
                            w_cofs_nx = r_cofs;
                        end
                    end
                    OP_HOLD:  w_wrap_nx = 1'b0;
                    default:  w_wrap_nx = 1'b0;
                endcase
            end else begin
                w_wrap_nx = 1'b0;
            end
        end

        // Only the low A bits of the product are kept. An A-bit multiply gives
        // exactly the same bits as the full 2A-bit product truncated.
        assign w_rsum      = r_row + A'(r_rofs);
        assign w_addr_calc = (w_rsum * w_step) + r_col + A'(r_cofs);

        // Channel state, CALC-stage address register and output pulses.
        always_ff @(posedge CLK or negedge RSTn) begin
            if (!RSTn) begin
                r_row       <= {A{1'b0}};
                r_col       <= {A{1'b0}};
                r_rofs      <= {OW{1'b0}};
                r_cofs      <= {OW{1'b0}};
                r_addr      <= {A{1'b0}};
                r_wrap_pend <= 1'b0;
                r_valid     <= 1'b0;
                r_wrapped   <= 1'b0;
            end else begin
                r_row     <= w_row_nx;
                r_col     <= w_col_nx;
                r_rofs    <= w_rofs_nx;
                r_cofs    <= w_cofs_nx;
                r_valid   <= w_upd;
                r_wrapped <= w_upd && r_wrap_pend;
                if (w_accept) begin
                    r_wrap_pend <= w_wrap_nx;
                end
                if (w_upd) begin
                    r_addr <= w_addr_calc;
                end
            end
        end

        assign addr[i*A +: A] = r_addr;
        assign addr_valid[i]  = r_valid;
        assign wrapped[i]     = r_wrapped;
    end

endmodule

// File: tb/tb_pe_addr_gen.sv
// -----------------------------------------------------------------------------
// tb_pe_addr_gen -- scoreboard bench for pe_addr_gen.
// Stimulus drives commands and pushes the expected response. The response is
// computed by an arithmetic model of the channel counters. A separate monitor
// pops an entry whenever addr_valid is seen and compares the masks, the address
// bus and the response latency.
// -----------------------------------------------------------------------------
module tb_pe_addr_gen;
    localparam int NCH = 2;
    localparam int A   = 7;
    localparam int OW  = 2;
    localparam int SW  = 4;
    localparam int CW  = 1;

    logic              CLK = 1'b0;
    logic              RSTn;
    logic              cmd_valid;
    logic              cmd_ready;
    logic [2:0]        cmd_op;
    logic [CW-1:0]     cmd_ch;
    logic              pe_sel;
    logic [OW-1:0]     set_data;
    logic [NCH*A-1:0]  cfg_step;
    logic [NCH*SW-1:0] cfg_col_stride;
    logic [NCH*SW-1:0] cfg_row_stride;
    logic [NCH*A-1:0]  cfg_cols;
    logic [NCH*A-1:0]  addr;
    logic [NCH-1:0]    addr_valid;
    logic [NCH-1:0]    wrapped;

    pe_addr_gen #(.NCH(NCH), .A(A), .OW(OW), .SW(SW)) dut (
        .CLK(CLK), .RSTn(RSTn), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_op(cmd_op), .cmd_ch(cmd_ch), .pe_sel(pe_sel), .set_data(set_data),
        .cfg_step(cfg_step), .cfg_col_stride(cfg_col_stride),
        .cfg_row_stride(cfg_row_stride), .cfg_cols(cfg_cols),
        .addr(addr), .addr_valid(addr_valid), .wrapped(wrapped)
    );

    always #5 CLK = ~CLK;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    always @(posedge CLK) cyc <= cyc + 1;

    // Behavioural model state: plain integers, everything taken mod 128.
    int m_row [NCH];
    int m_col [NCH];
    int m_rofs[NCH];
    int m_cofs[NCH];
    int m_addr[NCH];
    int c_step[NCH];
    int c_cs  [NCH];
    int c_rs  [NCH];
    int c_cols[NCH];

    typedef struct {
        logic [NCH-1:0]   vmask;
        logic [NCH*A-1:0] abus;
        logic [NCH-1:0]   wmask;
        int               cyc;
    } exp_t;
    exp_t q[$];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d", nm, act, exp);
        end
    endtask

    task automatic set_cfg(input int ch, input int step, input int cs, input int rs, input int cols);
        c_step[ch] = step; c_cs[ch] = cs; c_rs[ch] = rs; c_cols[ch] = cols;
        cfg_step[ch*A +: A]        = A'(step);
        cfg_col_stride[ch*SW +: SW] = SW'(cs);
        cfg_row_stride[ch*SW +: SW] = SW'(rs);
        cfg_cols[ch*A +: A]         = A'(cols);
    endtask

    task automatic model_reset();
        for (int c = 0; c < NCH; c++) begin
            m_row[c] = 0; m_col[c] = 0; m_rofs[c] = 0; m_cofs[c] = 0; m_addr[c] = 0;
        end
    endtask

    // Apply one accepted command to the model and queue the expected response.
    task automatic model_cmd(input int op, input int ch, input int sel, input int data);
        exp_t e;
        int   nc;
        e.vmask = '0; e.wmask = '0; e.abus = '0; e.cyc = cyc;
        if (ch >= NCH) return;
        case (op)
            0: begin m_row[ch] = 0; m_col[ch] = 0; end
            2, 4: begin
                nc = m_col[ch] + ((op == 2) ? c_cs[ch] : 1);
`ifdef AUTO_WRAP_EN
                if (c_cols[ch] != 0 && nc >= c_cols[ch]) begin
                    m_col[ch] = 0;
                    m_row[ch] = (m_row[ch] + c_rs[ch]) % 128;
                    e.wmask[ch] = 1'b1;
                end else begin
                    m_col[ch] = nc % 128;
                end
`else
                m_col[ch] = nc % 128;
`endif
            end
            3: begin m_row[ch] = (m_row[ch] + c_rs[ch]) % 128; m_col[ch] = 0; end
            5: if (sel != 0) m_rofs[ch] = data;
            6: if (sel != 0) m_cofs[ch] = data;
            7: for (int c = 0; c < NCH; c++) begin m_row[c] = 0; m_col[c] = 0; end
            default: ;
        endcase
        for (int c = 0; c < NCH; c++) begin
            if (op == 7 || c == ch) begin
                m_addr[c] = ((m_row[c] + m_rofs[c]) * c_step[c] + m_col[c] + m_cofs[c]) % 128;
                e.vmask[c] = 1'b1;
            end
            e.abus[c*A +: A] = A'(m_addr[c]);
        end
        q.push_back(e);
    endtask

    // Issue one command, then check that ready drops for exactly one cycle.
    task automatic send(input int op, input int ch, input int sel, input int data);
        @(negedge CLK);
        chk("ready_before", 32'(cmd_ready), 32'd1);
        cmd_valid = 1'b1;
        cmd_op    = 3'(op);
        cmd_ch    = CW'(ch);
        pe_sel    = sel[0];
        set_data  = OW'(data);
        @(posedge CLK);
        #1;
        cmd_valid = 1'b0;
        model_cmd(op, ch, sel, data);
        chk("ready_calc", 32'(cmd_ready), 32'd0);
        @(posedge CLK);
        #1;
        chk("ready_after", 32'(cmd_ready), 32'd1);
    endtask

    // Monitor: pop and compare on each addr_valid pulse.
    always @(negedge CLK) begin
        exp_t e;
        if (RSTn && addr_valid !== '0) begin
            if (q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_valid actual=%0b required=0", addr_valid);
            end else begin
                e = q.pop_front();
                chk("addr_valid", 32'(addr_valid), 32'(e.vmask));
                chk("addr_bus",   32'(addr),       32'(e.abus));
                chk("wrapped",    32'(wrapped),    32'(e.wmask));
                chk("latency",    32'(cyc),        32'(e.cyc + 1));
            end
        end else if (RSTn) begin
            chk("wrapped_idle", 32'(wrapped), 32'd0);
        end
    end

    int exp_a;

    initial begin
        RSTn = 1'b0; cmd_valid = 1'b0; cmd_op = 3'b000; cmd_ch = '0;
        pe_sel = 1'b0; set_data = '0;
        cfg_step = '0; cfg_col_stride = '0; cfg_row_stride = '0; cfg_cols = '0;
        for (int c = 0; c < NCH; c++) set_cfg(c, 0, 0, 0, 0);
        model_reset();
        repeat (3) @(posedge CLK);
        @(negedge CLK);
        RSTn = 1'b1;
        #1;
        chk("rst_addr",   32'(addr),       32'd0);
        chk("rst_valid",  32'(addr_valid), 32'd0);
        chk("rst_wrap",   32'(wrapped),    32'd0);
        chk("rst_ready",  32'(cmd_ready),  32'd1);

        // Back-to-back INCR on ch0: 2, 4, 6.
        set_cfg(0, 10, 2, 0, 0);
        set_cfg(1, 10, 0, 0, 0);
        send(2, 0, 0, 0);
        send(2, 0, 0, 0);
        send(2, 0, 0, 0);
        @(negedge CLK);
        chk("t2_addr0", 32'(addr[A-1:0]), 32'd6);
        chk("t2_addr1", 32'(addr[2*A-1:A]), 32'd0);

        // Row offset on ch1, then a SET with pe_sel low.
        send(5, 1, 1, 1);
        send(1, 1, 0, 0);
        send(5, 1, 0, 3);
        send(1, 1, 0, 0);
        @(negedge CLK);
        chk("t3_addr1", 32'(addr[2*A-1:A]), 32'd10);

        // JUMP: row 2 -> 20, then row 7 with step 20 -> 140 mod 128 = 12.
        set_cfg(0, 10, 2, 2, 0);
        send(3, 0, 0, 0);
        @(negedge CLK);
        chk("t4_jump", 32'(addr[A-1:0]), 32'd20);
        set_cfg(0, 20, 2, 5, 0);
        send(3, 0, 0, 0);
        @(negedge CLK);
        chk("t4_mod", 32'(addr[A-1:0]), 32'd12);

        // Column wrap at cols=4, then no wrap with cols=0.
        set_cfg(0, 20, 2, 5, 4);
        send(0, 0, 0, 0);
        send(2, 0, 0, 0);
        send(2, 0, 0, 0);
`ifdef AUTO_WRAP_EN
        exp_a = 100;
`else
        exp_a = 4;
`endif
        @(negedge CLK);
        chk("t5_wrap", 32'(addr[A-1:0]), 32'(exp_a));
        set_cfg(0, 20, 2, 5, 0);
        send(2, 0, 0, 0);
        send(7, 1, 0, 0);

        // Reset during CALC aborts the command.
        @(negedge CLK);
        cmd_valid = 1'b1; cmd_op = 3'b010; cmd_ch = '0;
        @(posedge CLK);
        #1;
        cmd_valid = 1'b0;
        RSTn = 1'b0;
        #1;
        chk("abort_addr",  32'(addr),       32'd0);
        chk("abort_valid", 32'(addr_valid), 32'd0);
        chk("abort_ready", 32'(cmd_ready),  32'd1);
        model_reset();
        repeat (2) @(posedge CLK);
        @(negedge CLK);
        RSTn = 1'b1;

        // Randomised commands and configuration.
        for (int n = 0; n < 400; n++) begin
            if ($urandom_range(0, 7) == 0) begin
                set_cfg(int'($urandom_range(0, NCH - 1)), int'($urandom_range(0, 127)),
                        int'($urandom_range(0, 15)), int'($urandom_range(0, 15)),
                        int'($urandom_range(0, 20)));
            end
            send(int'($urandom_range(0, 7)), int'($urandom_range(0, NCH - 1)),
                 int'($urandom_range(0, 1)), int'($urandom_range(0, 3)));
        end

        repeat (4) @(posedge CLK);
        chk("queue_empty", 32'(q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    // Global time bound.
    initial begin
        #200000;
        $display("FAIL timeout actual=running required=finished");
        $fatal(1);
    end
endmodule
